// File: rtl/ptr_wrap.sv
// Modulo-DEPTH address pointer with increment enable and synchronous clear.
// Wraps from DEPTH-1 to 0, so non-power-of-two depths are handled.
module ptr_wrap #(
  parameter int ADDRWIDTH = 4,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 inc,
  output logic [ADDRWIDTH-1:0] ptr
);

  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(DEPTH - 1);

  logic [ADDRWIDTH-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/dpram_fifo_ctl.sv
// FIFO controller around an external simple dual-port RAM (A = write, B = read,
// 1-cycle read latency). Holds only the pointers, the RAM word count and out_valid.
module dpram_fifo_ctl #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL     = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic [ADDRWIDTH:0]   level,
  output logic                 afull,
  output logic                 ena,
  output logic                 wea,
  output logic [ADDRWIDTH-1:0] addra,
  output logic [DATAWIDTH-1:0] dina,
  output logic                 enb,
  output logic [ADDRWIDTH-1:0] addrb,
  input  logic [DATAWIDTH-1:0] doutb
);

  localparam logic [ADDRWIDTH:0] DEPTH_L = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0] AFULL_L = (ADDRWIDTH+1)'(AFULL);

  logic [ADDRWIDTH:0]   r_ram_cnt;
  logic                 r_out_valid;
  logic [ADDRWIDTH-1:0] w_wr_ptr;
  logic [ADDRWIDTH-1:0] w_rd_ptr;
  logic                 w_wr_acc;
  logic                 w_rd_iss;
  logic                 w_clr;

  assign w_clr    = flush;
  assign in_ready = rstn && !flush && (r_ram_cnt < DEPTH_L);
  assign w_wr_acc = in_valid && in_ready;
  // Issuing a read only when ram_cnt > 0 keeps port B off the address port A writes this cycle.
  assign w_rd_iss = rstn && !flush && (r_ram_cnt != '0) && (!r_out_valid || out_ready);

  ptr_wrap #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_clr),
    .inc  (w_wr_acc),
    .ptr  (w_wr_ptr)
  );

  ptr_wrap #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (w_clr),
    .inc  (w_rd_iss),
    .ptr  (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_ram_cnt <= '0;
    end else begin
      case ({w_wr_acc, w_rd_iss})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

  // The word on doutb belongs to the last issue; it stays put while enb is low.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_out_valid <= 1'b0;
    end else if (w_rd_iss) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = doutb;

  assign ena   = w_wr_acc;
  assign wea   = w_wr_acc;
  assign addra = w_wr_ptr;
  assign dina  = in_data;
  assign enb   = w_rd_iss;
  assign addrb = w_rd_ptr;

  assign level = rstn ? (r_ram_cnt + {{ADDRWIDTH{1'b0}}, r_out_valid}) : '0;
  assign afull = rstn && (level >= AFULL_L);

endmodule

// File: tb/tb_dpram_fifo_ctl.sv
// Randomized scoreboard bench for dpram_fifo_ctl with a behavioural RAM model.
// The monitor compares against a word queue; stimulus only drives inputs.
module tb_dpram_fifo_ctl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rstn, flush, in_valid, in_ready, out_valid, out_ready, afull;
  logic [DW-1:0] in_data, out_data, dina, doutb;
  logic [AW:0]   level;
  logic          ena, wea, enb;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int stream_on = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .afull(afull),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb)
  );

  // External RAM: port A write, port B registered read that holds when enb is low.
  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
    if (ena && wea) mem[addra] <= dina;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
    end
  endtask

  // Reference model: ordered list of accepted words, plus write/read counts since clear.
  logic [DW-1:0] sb[$];
  int wr_idx = 0, rd_idx = 0, lat_cyc = -1, stream_n = 0;
  bit ov0_chk = 0, stall_prev = 0;
  logic [DW-1:0] stall_data;

  always @(negedge clk) begin
    bit empty_before;
    cyc_n++;
    if (!rstn) begin
      chk("rst_ena", ena, 0);
      chk("rst_wea", wea, 0);
      chk("rst_enb", enb, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_level", level, 0);
      chk("rst_afull", afull, 0);
      sb.delete(); wr_idx = 0; rd_idx = 0; lat_cyc = -1; ov0_chk = 1; stall_prev = 0;
    end else begin
      if (ov0_chk) chk("clear_out_valid", out_valid, 0);
      ov0_chk = 0;
      chk("level", level, sb.size());
      chk("afull", afull, sb.size() >= AFULL);
      chk("in_ready", in_ready, !flush && (sb.size() - int'(out_valid) < DEPTH));
      chk("ena", ena, in_valid && in_ready);
      if (ena) begin
        chk("wea", wea, 1);
        chk("addra", addra, wr_idx % DEPTH);
        chk("dina", dina, in_data);
      end
      if (lat_cyc == cyc_n) chk("first_word_latency", out_valid, 1);
      if (stall_prev && out_valid) chk("stall_stable", out_data, stall_data);
      if (out_valid && !out_ready) chk("stall_enb", enb, 0);
      if (stream_on != 0) begin
        chk("stream_out_valid", out_valid, 1);
        if (stream_n > 0) chk("stream_in_ready", in_ready, 1);
        stream_n++;
      end else begin
        stream_n = 0;
      end
      if (flush) begin
        chk("flush_enb", enb, 0);
        sb.delete(); wr_idx = 0; rd_idx = 0; lat_cyc = -1; ov0_chk = 1; stall_prev = 0;
      end else begin
        empty_before = (sb.size() == 0);
        if (enb) begin
          chk("addrb", addrb, rd_idx % DEPTH);
          rd_idx++;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("pop_underflow", 1, 0);
          else chk("out_data", out_data, sb.pop_front());
        end
        if (in_valid && in_ready) begin
          if (empty_before) lat_cyc = cyc_n + 2;
          sb.push_back(in_data);
          wr_idx++;
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents base, base+1, ... until n words are accepted, bounded by a cycle budget.
  task automatic push_words(input int n, input int base);
    int i = 0;
    int t = 0;
    bit acc;
    in_valid = 1'b1;
    in_data = DW'(base);
    while (i < n && t < 500) begin
      @(negedge clk);
      acc = in_ready;
      t++;
      step();
      if (acc) begin
        i++;
        in_data = DW'(base + i);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (i < n) begin
      errors++;
      $display("FAIL push_timeout: accepted %0d expected %0d", i, n);
    end
  endtask

  initial begin
    int stall;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    rstn = 1'b1;
    step();

    // Three back-to-back words, consumer always ready.
    out_ready = 1'b1;
    push_words(3, 8'h11 - 0);
    in_data = 8'h00;
    begin
      logic [DW-1:0] v [3];
      v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
      rstn = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        in_data = v[k];
        step();
      end
      in_valid = 1'b0;
    end
    repeat (6) step();

    // Fill to DEPTH+1 with the consumer stalled, then drain.
    out_ready = 1'b0;
    push_words(17, 0);
    repeat (3) step();
    out_ready = 1'b1;
    repeat (25) step();

    // Full FIFO streaming: one accept and one pop per cycle.
    out_ready = 1'b0;
    push_words(17, 8'h80);
    out_ready = 1'b1;
    in_valid = 1'b1;
    stream_on = 1;
    for (int k = 0; k < 40; k++) begin
      in_data = DW'($urandom);
      step();
    end
    stream_on = 0;
    in_valid = 1'b0;
    repeat (25) step();

    // Random traffic with consumer stalls of 1-5 cycles.
    stall = 0;
    for (int k = 0; k < 800; k++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_data = DW'($urandom);
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        stall = $urandom_range(1, 5) - 1;
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (25) step();

    // Flush at level 9 with a write pending, then the same with reset.
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      push_words(9, 8'h40);
      in_valid = 1'b1;
      in_data = 8'hEE;
      if (pass == 0) flush = 1'b1; else rstn = 1'b0;
      step();
      flush = 1'b0;
      rstn = 1'b1;
      in_valid = 1'b0;
      repeat (3) step();
      push_words(1, 8'h77);
      out_ready = 1'b1;
      repeat (6) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
